// File: rtl/pipe_idexe.sv
// -----------------------------------------------------------------------------
// pipe_idexe -- ID/EXE pipeline register with integrated hazard unit.
//
// Latches the decoded instruction from the ID stage into the EXE stage each
// cycle. Before latching, register-file operands are replaced by newer values
// still in flight in EXE or MEM (RAW forwarding). A load in EXE followed by a
// dependent instruction in ID stalls upstream for one cycle and sends a bubble
// into EXE. A control-flow flush also sends a bubble.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-low reset
//   d_*                 decoded instruction fields from ID
//   flush               discard the instruction currently in ID
//   ex_alud             ALU result of the instruction currently in EXE
//   m_wrf, m_wrf_addr,
//   m_wbdata            writeback intent and value of the instruction in MEM
//   e_*                 registered instruction fields presented to EXE
//   fwd_a, fwd_b        operand source: 00 regfile, 01 EXE, 10 MEM (comb)
//   stall               hold PC and IF/ID this cycle (comb)
//   stall_cnt           saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_idexe #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          d_valid,
   input  logic [AW-1:0] d_rs,
   input  logic [AW-1:0] d_rt,
   input  logic          d_use_rs,
   input  logic          d_use_rt,
   input  logic [DW-1:0] d_rd1,
   input  logic [DW-1:0] d_rd2,
   input  logic [DW-1:0] d_shamt32,
   input  logic [AW-1:0] d_wrf_addr,
   input  logic [3:0]    d_aluc,
   input  logic          d_wrf,
   input  logic          d_shift,
   input  logic          d_m2reg,
   input  logic          flush,
   input  logic [DW-1:0] ex_alud,
   input  logic          m_wrf,
   input  logic [AW-1:0] m_wrf_addr,
   input  logic [DW-1:0] m_wbdata,
   output logic          e_valid,
   output logic [DW-1:0] e_rd1,
   output logic [DW-1:0] e_rd2,
   output logic [DW-1:0] e_shamt32,
   output logic [AW-1:0] e_wrf_addr,
   output logic [3:0]    e_aluc,
   output logic          e_wrf,
   output logic          e_shift,
   output logic          e_m2reg,
   output logic [1:0]    fwd_a,
   output logic [1:0]    fwd_b,
   output logic          stall,
   output logic [CW-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EXE = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   fwd_sel_t      sel_a, sel_b;
   logic [DW-1:0] op_a, op_b;
   logic          exe_src_ok;
   logic          mem_src_ok;
   logic          load_in_exe;
   logic          hz;
   logic          bubble;

   // A load's EXE result is an address, not data, so a load in EXE can never
   // forward; that case is covered by the load-use stall instead.
   assign exe_src_ok  = e_valid & e_wrf & ~e_m2reg & (e_wrf_addr != '0);
   assign mem_src_ok  = m_wrf & (m_wrf_addr != '0);
   assign load_in_exe = e_valid & e_wrf & e_m2reg & (e_wrf_addr != '0);

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_a = FWD_RF;
      op_a  = d_rd1;
      if (exe_src_ok && (e_wrf_addr == d_rs)) begin
         sel_a = FWD_EXE;
         op_a  = ex_alud;
      end else if (mem_src_ok && (m_wrf_addr == d_rs)) begin
         sel_a = FWD_MEM;
         op_a  = m_wbdata;
      end
   end

   always_comb begin
      sel_b = FWD_RF;
      op_b  = d_rd2;
      if (exe_src_ok && (e_wrf_addr == d_rt)) begin
         sel_b = FWD_EXE;
         op_b  = ex_alud;
      end else if (mem_src_ok && (m_wrf_addr == d_rt)) begin
         sel_b = FWD_MEM;
         op_b  = m_wbdata;
      end
   end

   assign fwd_a = sel_a;
   assign fwd_b = sel_b;

   // Source-use flags gate only the stall; forwarding is harmless when the
   // operand is not read.
   assign hz = d_valid & load_in_exe &
               ((d_use_rs & (d_rs == e_wrf_addr)) |
                (d_use_rt & (d_rt == e_wrf_addr)));

   // A flushed instruction is thrown away, so there is nothing to hold.
   assign stall  = hz & ~flush;
   assign bubble = flush | stall | ~d_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         e_valid    <= 1'b0;
         e_rd1      <= '0;
         e_rd2      <= '0;
         e_shamt32  <= '0;
         e_wrf_addr <= '0;
         e_aluc     <= '0;
         e_wrf      <= 1'b0;
         e_shift    <= 1'b0;
         e_m2reg    <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         if (bubble) begin
            // Bubbles are all-zero, data included, so EXE sees a fixed pattern.
            e_valid    <= 1'b0;
            e_rd1      <= '0;
            e_rd2      <= '0;
            e_shamt32  <= '0;
            e_wrf_addr <= '0;
            e_aluc     <= '0;
            e_wrf      <= 1'b0;
            e_shift    <= 1'b0;
            e_m2reg    <= 1'b0;
         end else begin
            e_valid    <= 1'b1;
            e_rd1      <= op_a;
            e_rd2      <= op_b;
            e_shamt32  <= d_shamt32;
            e_wrf_addr <= d_wrf_addr;
            e_aluc     <= d_aluc;
            e_wrf      <= d_wrf;
            e_shift    <= d_shift;
            e_m2reg    <= d_m2reg;
         end

         // Saturate rather than wrap so a long run never reads as few stalls.
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_idexe.sv
// -----------------------------------------------------------------------------
// tb_pipe_idexe -- directed self-checking bench for pipe_idexe.
// The DUT is built with CW=4 so stall counter saturation is reachable quickly.
// Inputs change 1 ns after the rising edge; combinational outputs are checked
// 1 ns later, registered outputs 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_idexe;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          d_valid;
   logic [AW-1:0] d_rs;
   logic [AW-1:0] d_rt;
   logic          d_use_rs;
   logic          d_use_rt;
   logic [DW-1:0] d_rd1;
   logic [DW-1:0] d_rd2;
   logic [DW-1:0] d_shamt32;
   logic [AW-1:0] d_wrf_addr;
   logic [3:0]    d_aluc;
   logic          d_wrf;
   logic          d_shift;
   logic          d_m2reg;
   logic          flush;
   logic [DW-1:0] ex_alud;
   logic          m_wrf;
   logic [AW-1:0] m_wrf_addr;
   logic [DW-1:0] m_wbdata;
   logic          e_valid;
   logic [DW-1:0] e_rd1;
   logic [DW-1:0] e_rd2;
   logic [DW-1:0] e_shamt32;
   logic [AW-1:0] e_wrf_addr;
   logic [3:0]    e_aluc;
   logic          e_wrf;
   logic          e_shift;
   logic          e_m2reg;
   logic [1:0]    fwd_a;
   logic [1:0]    fwd_b;
   logic          stall;
   logic [CW-1:0] stall_cnt;

   int            checks;
   int            errors;
   logic [CW-1:0] exp_cnt;

   pipe_idexe #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .d_valid    (d_valid),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_use_rs   (d_use_rs),
      .d_use_rt   (d_use_rt),
      .d_rd1      (d_rd1),
      .d_rd2      (d_rd2),
      .d_shamt32  (d_shamt32),
      .d_wrf_addr (d_wrf_addr),
      .d_aluc     (d_aluc),
      .d_wrf      (d_wrf),
      .d_shift    (d_shift),
      .d_m2reg    (d_m2reg),
      .flush      (flush),
      .ex_alud    (ex_alud),
      .m_wrf      (m_wrf),
      .m_wrf_addr (m_wrf_addr),
      .m_wbdata   (m_wbdata),
      .e_valid    (e_valid),
      .e_rd1      (e_rd1),
      .e_rd2      (e_rd2),
      .e_shamt32  (e_shamt32),
      .e_wrf_addr (e_wrf_addr),
      .e_aluc     (e_aluc),
      .e_wrf      (e_wrf),
      .e_shift    (e_shift),
      .e_m2reg    (e_m2reg),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .stall      (stall),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one ID instruction; shamt mirrors rs so it is easy to predict.
   task automatic drive_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic urs, input logic urt,
                           input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                           input logic [AW-1:0] wa, input logic [3:0] aluc,
                           input logic wrf, input logic m2reg);
      d_valid    = v;
      d_rs       = rs;
      d_rt       = rt;
      d_use_rs   = urs;
      d_use_rt   = urt;
      d_rd1      = rd1;
      d_rd2      = rd2;
      d_shamt32  = {{(DW-AW){1'b0}}, rs};
      d_wrf_addr = wa;
      d_aluc     = aluc;
      d_wrf      = wrf;
      d_shift    = 1'b0;
      d_m2reg    = m2reg;
   endtask

   task automatic set_mem(input logic wrf, input logic [AW-1:0] wa, input logic [DW-1:0] wb);
      m_wrf      = wrf;
      m_wrf_addr = wa;
      m_wbdata   = wb;
   endtask

   task automatic test_reset();
      rst     = 1'b0;
      flush   = 1'b0;
      ex_alud = 32'h0;
      set_mem(1'b0, 5'd0, 32'h0);
      drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'hDEAD_0001, 32'hBEEF_0002, 5'd7, 4'hA, 1'b1, 1'b0);
      d_shift = 1'b1;
      tick();
      tick();
      checks++;
      if ({e_valid, e_rd1, e_rd2, e_shamt32, e_wrf_addr, e_aluc, e_wrf, e_shift, e_m2reg} !== '0) begin
         errors++;
         $display("FAIL reset_e_regs: got v=%b rd1=%h rd2=%h sh=%h wa=%0d aluc=%h wrf=%b shift=%b m2r=%b, want all 0",
                  e_valid, e_rd1, e_rd2, e_shamt32, e_wrf_addr, e_aluc, e_wrf, e_shift, e_m2reg);
      end
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({e_valid, e_rd1, e_rd2, e_shamt32, e_wrf_addr, e_aluc, e_wrf, e_shift, e_m2reg} !==
          {1'b1, 32'hDEAD_0001, 32'hBEEF_0002, 32'd1, 5'd7, 4'hA, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_release_latch: got v=%b rd1=%h rd2=%h sh=%h wa=%0d aluc=%h wrf=%b shift=%b m2r=%b",
                  e_valid, e_rd1, e_rd2, e_shamt32, e_wrf_addr, e_aluc, e_wrf, e_shift, e_m2reg);
      end
   endtask

   task automatic test_exe_forward();
      // Producer: add writing $3.
      set_mem(1'b0, 5'd0, 32'h0);
      drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'h1, 32'h2, 5'd3, 4'h2, 1'b1, 1'b0);
      tick();
      // Consumer reads rs=$3; EXE value must replace the regfile value. It
      // also writes $3 so the next step still sees a $3 producer in EXE.
      ex_alud = 32'h0000_0055;
      drive_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 32'h11, 32'h22, 5'd3, 4'h2, 1'b1, 1'b0);
      #1;
      checks++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b00 || stall !== 1'b0) begin
         errors++;
         $display("FAIL exe_fwd_sel: got fwd_a=%b fwd_b=%b stall=%b want 01 00 0", fwd_a, fwd_b, stall);
      end
      tick();
      checks++;
      if (e_rd1 !== 32'h55 || e_rd2 !== 32'h22) begin
         errors++;
         $display("FAIL exe_fwd_data: got rd1=%h rd2=%h want 00000055 00000022", e_rd1, e_rd2);
      end
      // Both EXE and MEM target $3: EXE is newer and must win.
      set_mem(1'b1, 5'd3, 32'h66);
      drive_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22, 5'd3, 4'h2, 1'b1, 1'b0);
      #1;
      checks++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
         errors++;
         $display("FAIL exe_over_mem_sel: got fwd_a=%b fwd_b=%b want 01 01", fwd_a, fwd_b);
      end
      tick();
      checks++;
      if (e_rd1 !== 32'h55 || e_rd2 !== 32'h55) begin
         errors++;
         $display("FAIL exe_over_mem_data: got rd1=%h rd2=%h want 00000055 00000055", e_rd1, e_rd2);
      end
      // Mixed: A from MEM ($7), B from EXE ($3).
      set_mem(1'b1, 5'd7, 32'h77);
      drive_id(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22, 5'd9, 4'h2, 1'b1, 1'b0);
      #1;
      checks++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
         errors++;
         $display("FAIL mixed_fwd_sel: got fwd_a=%b fwd_b=%b want 10 01", fwd_a, fwd_b);
      end
      tick();
      checks++;
      if (e_rd1 !== 32'h77 || e_rd2 !== 32'h55 || e_wrf_addr !== 5'd9) begin
         errors++;
         $display("FAIL mixed_fwd_data: got rd1=%h rd2=%h wa=%0d want 00000077 00000055 9",
                  e_rd1, e_rd2, e_wrf_addr);
      end
   endtask

   task automatic test_zero_guard();
      set_mem(1'b0, 5'd0, 32'h0);
      drive_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 32'h8, 32'h9, 5'd0, 4'h2, 1'b1, 1'b0);
      tick();
      ex_alud = 32'h88;
      set_mem(1'b1, 5'd0, 32'h99);
      drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd10, 4'h2, 1'b1, 1'b0);
      #1;
      checks++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         errors++;
         $display("FAIL zero_guard_sel: got fwd_a=%b fwd_b=%b want 00 00", fwd_a, fwd_b);
      end
      tick();
      checks++;
      if (e_rd1 !== 32'h0 || e_rd2 !== 32'h0 || e_valid !== 1'b1) begin
         errors++;
         $display("FAIL zero_guard_data: got rd1=%h rd2=%h v=%b want 0 0 1", e_rd1, e_rd2, e_valid);
      end
   endtask

   task automatic test_load_use();
      set_mem(1'b0, 5'd0, 32'h0);
      drive_id(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 32'hA, 32'hB, 5'd5, 4'h2, 1'b1, 1'b1);
      tick();
      // Same register read, but not used: forwarding rules allow nothing from a
      // load and no stall is needed.
      drive_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 32'h1, 32'h1111, 5'd6, 4'h3, 1'b1, 1'b0);
      #1;
      checks++;
      if (stall !== 1'b0 || fwd_b !== 2'b00) begin
         errors++;
         $display("FAIL load_unused_rt: got stall=%b fwd_b=%b want 0 00", stall, fwd_b);
      end
      d_use_rt = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1 || fwd_b !== 2'b00) begin
         errors++;
         $display("FAIL load_use_stall: got stall=%b fwd_b=%b want 1 00", stall, fwd_b);
      end
      tick();
      if (exp_cnt != '1) exp_cnt = exp_cnt + 4'd1;
      checks++;
      if (e_valid !== 1'b0 || e_rd2 !== 32'h0 || e_m2reg !== 1'b0 || stall_cnt !== exp_cnt || stall !== 1'b0) begin
         errors++;
         $display("FAIL load_use_bubble: got v=%b rd2=%h m2r=%b cnt=%0d stall=%b want 0 0 0 %0d 0",
                  e_valid, e_rd2, e_m2reg, stall_cnt, stall, exp_cnt);
      end
      // Load now in MEM; held consumer picks its value from m_wbdata.
      set_mem(1'b1, 5'd5, 32'h0000_ABCD);
      #1;
      checks++;
      if (fwd_b !== 2'b10 || stall !== 1'b0) begin
         errors++;
         $display("FAIL load_use_mem_sel: got fwd_b=%b stall=%b want 10 0", fwd_b, stall);
      end
      tick();
      checks++;
      if (e_valid !== 1'b1 || e_rd2 !== 32'hABCD || e_wrf_addr !== 5'd6 || stall_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL load_use_mem_data: got v=%b rd2=%h wa=%0d cnt=%0d want 1 0000abcd 6 %0d",
                  e_valid, e_rd2, e_wrf_addr, stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_flush();
      set_mem(1'b0, 5'd0, 32'h0);
      drive_id(1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 32'hC, 32'hD, 5'd5, 4'h2, 1'b1, 1'b1);
      tick();
      flush = 1'b1;
      drive_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 32'h1234, 32'h5678, 5'd6, 4'h4, 1'b1, 1'b0);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_stall: got stall=%b want 0", stall);
      end
      tick();
      flush = 1'b0;
      checks++;
      if ({e_valid, e_rd1, e_rd2, e_shamt32, e_wrf_addr, e_aluc, e_wrf, e_shift, e_m2reg} !== '0 ||
          stall_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL flush_bubble: got v=%b rd1=%h rd2=%h wa=%0d wrf=%b cnt=%0d want all 0, cnt %0d",
                  e_valid, e_rd1, e_rd2, e_wrf_addr, e_wrf, stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      set_mem(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 20; i++) begin
         drive_id(1'b1, 5'd14, 5'd15, 1'b1, 1'b1, 32'hE, 32'hF, 5'd5, 4'h2, 1'b1, 1'b1);
         tick();
         drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 32'h5, 32'h0, 5'd6, 4'h2, 1'b1, 1'b0);
         #1;
         checks++;
         if (stall !== 1'b1) begin
            errors++;
            $display("FAIL sat_stall_%0d: got stall=%b want 1", i, stall);
         end
         tick();
         if (exp_cnt != '1) exp_cnt = exp_cnt + 4'd1;
         checks++;
         if (stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sat_cnt_%0d: got %0d want %0d", i, stall_cnt, exp_cnt);
         end
      end
      checks++;
      if (stall_cnt !== 4'd15) begin
         errors++;
         $display("FAIL sat_final: got %0d want 15", stall_cnt);
      end
   endtask

   task automatic test_reset_abort();
      drive_id(1'b1, 5'd14, 5'd15, 1'b1, 1'b1, 32'hE, 32'hF, 5'd5, 4'h2, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 32'h5, 32'h0, 5'd6, 4'h2, 1'b1, 1'b0);
      rst = 1'b0;
      tick();
      exp_cnt = '0;
      checks++;
      if ({e_valid, e_rd1, e_rd2, e_shamt32, e_wrf_addr, e_aluc, e_wrf, e_shift, e_m2reg} !== '0 ||
          stall_cnt !== exp_cnt || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: got v=%b wa=%0d m2r=%b cnt=%0d stall=%b want all 0",
                  e_valid, e_wrf_addr, e_m2reg, stall_cnt, stall);
      end
      rst = 1'b1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = '0;
      #2;
      test_reset();
      test_exe_forward();
      test_zero_guard();
      test_load_use();
      test_flush();
      test_saturation();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_idexe.md
Name: pipe_idexe

Overview:
- ID/EXE pipeline register with an integrated hazard unit. Sits between the decode stage (pipe_id) and the execute stage (pipe_exe).
- Latches decoded operands and control each cycle.
- Resolves RAW hazards by forwarding EXE/MEM results into ID operands before latching.
- Detects load-use hazards, stalls upstream, and inserts a bubble. Also inserts a bubble on control-flow flush.

Parameters:
- DW, 32, datapath width
- AW, 5, register-address width
- CW, 16, stall-counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active low
- d_valid  in  1  ID holds a real instruction
- d_rs  in  AW  source register A address
- d_rt  in  AW  source register B address
- d_use_rs  in  1  instruction reads rs
- d_use_rt  in  1  instruction reads rt
- d_rd1  in  DW  register-file read A
- d_rd2  in  DW  register-file read B
- d_shamt32  in  DW  zero-extended shamt
- d_wrf_addr  in  AW  destination register
- d_aluc  in  4  ALU control
- d_wrf  in  1  write register file
- d_shift  in  1  alua selects shamt
- d_m2reg  in  1  instruction is a load
- flush  in  1  discard ID instruction (taken branch/jump/jr)
- ex_alud  in  DW  current EXE ALU result (from pipe_exe)
- m_wrf  in  1  MEM-stage instruction writes register file
- m_wrf_addr  in  AW  MEM-stage destination register
- m_wbdata  in  DW  MEM-stage final writeback value
- e_valid  out  1  EXE instruction valid
- e_rd1  out  DW  latched, forwarded operand A
- e_rd2  out  DW  latched, forwarded operand B
- e_shamt32  out  DW  latched shamt
- e_wrf_addr  out  AW  latched destination
- e_aluc  out  4  latched ALU control
- e_wrf  out  1  latched write enable
- e_shift  out  1  latched shift select
- e_m2reg  out  1  latched load flag
- fwd_a  out  2  forward select A: 00 regfile, 01 EXE, 10 MEM
- fwd_b  out  2  forward select B: same encoding as fwd_a
- stall  out  1  hold PC and IF/ID (drives pc_ena low)
- stall_cnt  out  CW  saturating count of stall cycles

Behaviour:
- Reset: at posedge clk with rst==0, every registered output (all e_* ports and stall_cnt) clears to 0. Reset has priority over all other inputs and aborts any stall or flush in progress.
- Forwarding (combinational from ID inputs and current e_* registers). For operand A, fwd_a is the first match in this order:
  - 01 if e_valid & e_wrf & ~e_m2reg & e_wrf_addr!=0 & e_wrf_addr==d_rs; selected value is ex_alud.
  - 10 if m_wrf & m_wrf_addr!=0 & m_wrf_addr==d_rs; selected value is m_wbdata.
  - 00 otherwise; selected value is d_rd1.
  - EXE outranks MEM when both match.
- Operand B uses the same rules with d_rt, d_rd2 and fwd_b.
- Register $0 never forwards.
- Forwarding is independent of d_use_rs/d_use_rt; those inputs only gate the stall.
- Load-use hazard: hz = d_valid & e_valid & e_wrf & e_m2reg & e_wrf_addr!=0 & ((d_use_rs & d_rs==e_wrf_addr) | (d_use_rt & d_rt==e_wrf_addr)).
- stall = hz & ~flush. A flushed instruction is discarded, so nothing needs to be held.
- Register update at posedge clk with rst==1, in priority order:
  - flush=1: load bubble.
  - else stall=1: load bubble.
  - else d_valid=0: load bubble.
  - else load d_* fields, with forwarded values into e_rd1/e_rd2, and set e_valid=1.
- Bubble: every e_* output is 0, including data fields, so bubbles are deterministic for the checker.
- Latency: one cycle from ID to e_* outputs.
- A stall lasts exactly one cycle: the bubble clears e_m2reg, so on the next cycle the load has reached MEM and the dependent operand forwards from m_wbdata.
- stall_cnt increments on each posedge where stall==1 and saturates at 2^CW-1 (no wrap).
- stall, fwd_a and fwd_b are purely combinational with no registered delay.

Test Plan:
- Reset: drive rst=0 for 2 cycles with d_valid=1 and arbitrary data -> all e_* = 0 and stall_cnt = 0; on the first edge with rst=1, inputs latch normally.
- EXE forward: e holds add to $3 (e_wrf=1, e_m2reg=0); ID reads rs=$3 with ex_alud=0x0000_0055 and d_rd1=0x11 -> fwd_a=01 and e_rd1=0x55 after the edge. With both EXE and MEM writing $3 (m_wbdata=0x66) -> EXE value 0x55 wins.
- $0 guard: e and m both write $0; ID reads rs=rt=$0 with d_rd1=d_rd2=0 -> fwd_a=fwd_b=00 and e_rd1=e_rd2=0.
- Load-use: e holds a load to $5; ID reads rt=$5 with d_use_rt=1 -> stall=1 for exactly 1 cycle, next e_valid=0, stall_cnt=1. On the following cycle (m_wrf_addr=5, m_wbdata=0xABCD) -> fwd_b=10 and e_rd2=0xABCD.
- Flush overrides stall: load-use condition present with flush=1 -> stall=0, e_* bubble, stall_cnt unchanged.
- Saturation: with CW=4, hold the load-use condition (static e regs forced via repeated loads) for 20 stall cycles -> stall_cnt stops at 15.
